// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: issues sequential PCs/IDs under a credit limit,
// passes returned instructions to decode, drains over-fetch after inst_last.
//
//  state | meaning
//  IDLE  | waiting for start; no fetch, no return acceptance
//  FETCH | issuing fetches while credit remains, forwarding returns to decode
//  DRAIN | discarding over-fetched returns until nothing is in flight
//  DONE  | one-cycle exec_finish pulse, then back to IDLE
module fetch_ctrl #(
    parameter int PC_BIT       = 8,
    parameter int INST_ID_BIT  = 8,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PC_BIT-1:0]      start_pc,
    output logic                   fetch_vld,
    input  logic                   fetch_rdy,
    output logic [PC_BIT-1:0]      fetch_pc,
    output logic [INST_ID_BIT-1:0] fetch_id,
    input  logic                   inst_vld,
    output logic                   inst_rdy,
    input  logic [INST_ID_BIT-1:0] inst_id,
    input  logic                   inst_last,
    output logic                   dec_vld,
    input  logic                   dec_rdy,
    input  logic                   retire_vld,
    output logic                   busy,
    output logic                   exec_finish,
    output logic                   proto_err
);
    localparam int CNT_BIT = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_BIT-1:0] MAX_CNT = CNT_BIT'(MAX_INFLIGHT);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [PC_BIT-1:0]      pc_q, pc_d;
    logic [INST_ID_BIT-1:0] next_id_q, next_id_d;
    logic [INST_ID_BIT-1:0] exp_id_q, exp_id_d;
    logic [CNT_BIT-1:0]     inflight_q, inflight_d;
    logic                   proto_err_q, proto_err_d;

    logic                   fetch_hs, ret_hs, discard;
    logic [CNT_BIT:0]       cnt_up, cnt_dn;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            next_id_q   <= '0;
            exp_id_q    <= '0;
            inflight_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            next_id_q   <= next_id_d;
            exp_id_q    <= exp_id_d;
            inflight_q  <= inflight_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   if (ret_hs && inst_last) state_d = DRAIN;
            DRAIN:   if (inflight_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_vld = 1'b0;
        inst_rdy  = 1'b0;
        dec_vld   = 1'b0;
        case (state_q)
            FETCH: begin
                fetch_vld = (inflight_q < MAX_CNT);
                inst_rdy  = dec_rdy;
                dec_vld   = inst_vld;
            end
            DRAIN:   inst_rdy = 1'b1;
            default: ;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign exec_finish = (state_q == DONE);
    assign fetch_pc    = pc_q;
    assign fetch_id    = next_id_q;
    assign proto_err   = proto_err_q;

    assign fetch_hs = fetch_vld & fetch_rdy;
    assign ret_hs   = inst_vld & inst_rdy;
    assign discard  = (state_q == DRAIN) & ret_hs;

    // Net credit change; one extra bit lets a retire against an empty count be detected.
    assign cnt_up = {1'b0, inflight_q} + (CNT_BIT+1)'(fetch_hs);
    assign cnt_dn = (CNT_BIT+1)'(retire_vld) + (CNT_BIT+1)'(discard);

    always_comb begin
        pc_d        = pc_q;
        next_id_d   = next_id_q;
        exp_id_d    = exp_id_q;
        inflight_d  = inflight_q;
        proto_err_d = proto_err_q;
        if (state_q == IDLE) begin
            if (start) begin
                pc_d        = start_pc;
                next_id_d   = '0;
                exp_id_d    = '0;
                inflight_d  = '0;
                proto_err_d = 1'b0;
            end
        end else begin
            if (fetch_hs) begin
                pc_d      = pc_q + PC_BIT'(1);
                next_id_d = next_id_q + INST_ID_BIT'(1);
            end
            if (ret_hs && (state_q == FETCH)) begin
                exp_id_d = exp_id_q + INST_ID_BIT'(1);
                if (inst_id != exp_id_q) proto_err_d = 1'b1;
            end
            if (cnt_up < cnt_dn) begin
                inflight_d  = '0;
                proto_err_d = 1'b1;
            end else begin
                inflight_d = CNT_BIT'(cnt_up - cnt_dn);
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a memory/decode/retire environment with a return
// scoreboard, plus directed scenario tasks.
module tb_fetch_ctrl;
    localparam int PC_BIT       = 8;
    localparam int INST_ID_BIT  = 8;
    localparam int MAX_INFLIGHT = 4;

    logic clk = 1'b0;
    logic rst, start, fetch_rdy, inst_vld, inst_last, dec_rdy, retire_vld;
    logic [PC_BIT-1:0] start_pc, fetch_pc;
    logic [INST_ID_BIT-1:0] fetch_id, inst_id;
    logic fetch_vld, inst_rdy, dec_vld, busy, exec_finish, proto_err;

    fetch_ctrl #(
        .PC_BIT(PC_BIT), .INST_ID_BIT(INST_ID_BIT), .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
        .fetch_vld(fetch_vld), .fetch_rdy(fetch_rdy), .fetch_pc(fetch_pc), .fetch_id(fetch_id),
        .inst_vld(inst_vld), .inst_rdy(inst_rdy), .inst_id(inst_id), .inst_last(inst_last),
        .dec_vld(dec_vld), .dec_rdy(dec_rdy), .retire_vld(retire_vld),
        .busy(busy), .exec_finish(exec_finish), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int                     idx;
        logic [INST_ID_BIT-1:0] id;
        logic                   exp_dec;
        int                     t;
    } ent_t;

    ent_t mq[$];
    int   rq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    bit man_rst, man_start, man_retire, fetch_rdy_en, ret_en, auto_retire, dec_hold, chk_stall_rdy;
    logic [PC_BIT-1:0] man_start_pc;
    int last_idx, corrupt_idx, corrupt_id, fst_lo, fst_hi, dst_lo, dst_hi;

    logic [PC_BIT-1:0]      m_pc;
    logic [INST_ID_BIT-1:0] m_id;
    int n_fetch, n_dec, n_disc, n_finish;

    logic s_fetch_vld, s_inst_rdy, s_dec_vld, s_busy, s_exec_finish, s_proto_err;
    logic [PC_BIT-1:0]      s_fetch_pc;
    logic [INST_ID_BIT-1:0] s_fetch_id;
    bit prev_stall;
    logic [PC_BIT-1:0]      prev_pc;
    logic [INST_ID_BIT-1:0] prev_id;

    task automatic init_knobs();
        man_rst = 0; man_start = 0; man_retire = 0; man_start_pc = '0;
        fetch_rdy_en = 1; ret_en = 1; auto_retire = 1; dec_hold = 0; chk_stall_rdy = 0;
        last_idx = 1000; corrupt_idx = -1; corrupt_id = 0;
        fst_lo = 1; fst_hi = 0; dst_lo = 1; dst_hi = 0;
    endtask

    // One clock: drive inputs, sample outputs mid-cycle, update the environment.
    task automatic run_cycle();
        int   rel;
        ent_t e;
        bit   fhs, rhs, dhs;
        rel = cyc - t0;
        rst = man_rst;
        start = man_start;
        start_pc = man_start_pc;
        fetch_rdy = fetch_rdy_en && !(rel >= fst_lo && rel <= fst_hi);
        dec_rdy = !dec_hold && !(rel >= dst_lo && rel <= dst_hi);
        inst_vld = 1'b0; inst_id = '0; inst_last = 1'b0;
        if (ret_en && mq.size() > 0 && mq[0].t <= cyc) begin
            inst_vld = 1'b1;
            inst_id = (mq[0].idx == corrupt_idx) ? INST_ID_BIT'(corrupt_id) : mq[0].id;
            inst_last = (mq[0].idx == last_idx);
        end
        retire_vld = man_retire || (rq.size() > 0 && rq[0] == cyc);
        #1;
        s_fetch_vld = fetch_vld; s_inst_rdy = inst_rdy; s_dec_vld = dec_vld; s_busy = busy;
        s_exec_finish = exec_finish; s_proto_err = proto_err;
        s_fetch_pc = fetch_pc; s_fetch_id = fetch_id;
        if (!man_rst) begin
            fhs = fetch_vld && fetch_rdy;
            rhs = inst_vld && inst_rdy;
            dhs = dec_vld && dec_rdy;
            if (prev_stall && fetch_vld) begin
                checks++;
                if (fetch_pc !== prev_pc || fetch_id !== prev_id) begin
                    errors++;
                    $display("FAIL stall_hold: pc/id %h/%h required %h/%h", fetch_pc, fetch_id, prev_pc, prev_id);
                end
            end
            if (chk_stall_rdy && !dec_rdy) begin
                checks++;
                if (inst_rdy !== 1'b0) begin
                    errors++;
                    $display("FAIL dec_stall_rdy: inst_rdy %b required 0", inst_rdy);
                end
            end
            if (fhs) begin
                checks++;
                if (fetch_pc !== m_pc || fetch_id !== m_id) begin
                    errors++;
                    $display("FAIL fetch_seq: pc/id %h/%h required %h/%h", fetch_pc, fetch_id, m_pc, m_id);
                end
                e.idx = n_fetch; e.id = m_id; e.exp_dec = (n_fetch <= last_idx); e.t = cyc + 1;
                mq.push_back(e);
                n_fetch++; m_pc++; m_id++;
            end
            if (rhs) begin
                e = mq.pop_front();
                checks++;
                if (dec_vld !== e.exp_dec) begin
                    errors++;
                    $display("FAIL ret_dec idx %0d: dec_vld %b required %b", e.idx, dec_vld, e.exp_dec);
                end
                if (dhs) begin
                    n_dec++;
                    if (auto_retire) rq.push_back(cyc + 3);
                end else begin
                    n_disc++;
                end
            end
            if (exec_finish === 1'b1) n_finish++;
            prev_stall = fetch_vld && !fetch_rdy;
            prev_pc = fetch_pc;
            prev_id = fetch_id;
        end
        if (rq.size() > 0 && rq[0] == cyc) void'(rq.pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        man_rst = 1;
        run_cycle();
        run_cycle();
        man_rst = 0;
        mq.delete(); rq.delete();
        prev_stall = 0;
    endtask

    task automatic begin_prog(input logic [PC_BIT-1:0] pc, input int last);
        mq.delete(); rq.delete();
        m_pc = pc; m_id = '0;
        n_fetch = 0; n_dec = 0; n_disc = 0; n_finish = 0;
        last_idx = last; prev_stall = 0;
        t0 = cyc;
        man_start = 1; man_start_pc = pc;
        run_cycle();
        man_start = 0;
    endtask

    task automatic wait_finish(input int budget, input string tag);
        int n;
        n = 0;
        while (n_finish == 0 && n < budget) begin
            run_cycle();
            n++;
        end
        checks++;
        if (n_finish == 0) begin
            errors++;
            $display("FAIL %s_finish: no exec_finish within %0d cycles", tag, budget);
        end else begin
            run_cycle();
            checks++;
            if (s_busy !== 1'b0 || s_exec_finish !== 1'b0 || n_finish != 1) begin
                errors++;
                $display("FAIL %s_pulse: busy %b finish %b pulses %0d required 0 0 1",
                         tag, s_busy, s_exec_finish, n_finish);
            end
        end
    endtask

    task automatic test_reset();
        init_knobs();
        do_reset();
        run_cycle();
        checks++;
        if ({s_fetch_vld, s_inst_rdy, s_dec_vld, s_busy, s_exec_finish, s_proto_err} !== 6'b0 ||
            s_fetch_pc !== '0 || s_fetch_id !== '0) begin
            errors++;
            $display("FAIL reset_outputs: vld/rdy/dec/busy/fin/err %b%b%b%b%b%b pc %h id %h required all 0",
                     s_fetch_vld, s_inst_rdy, s_dec_vld, s_busy, s_exec_finish, s_proto_err, s_fetch_pc, s_fetch_id);
        end
        man_retire = 1;
        run_cycle();
        man_retire = 0;
        run_cycle();
        checks++;
        if (s_proto_err !== 1'b0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_retire: proto_err %b busy %b required 0 0", s_proto_err, s_busy);
        end
    endtask

    task automatic test_basic();
        init_knobs();
        begin_prog(8'h10, 5);
        run_cycle();
        checks++;
        if (s_fetch_vld !== 1'b1 || s_fetch_pc !== 8'h10 || s_fetch_id !== 8'h00) begin
            errors++;
            $display("FAIL first_fetch: vld %b pc %h id %h required 1 10 00", s_fetch_vld, s_fetch_pc, s_fetch_id);
        end
        wait_finish(200, "basic");
        checks++;
        if (n_dec != 6) begin
            errors++;
            $display("FAIL basic_dec_count: %0d required 6", n_dec);
        end
        checks++;
        if (n_disc < 1 || mq.size() != 0 || n_fetch != n_dec + n_disc) begin
            errors++;
            $display("FAIL basic_discard: disc %0d left %0d fetched %0d required >=1 0 %0d",
                     n_disc, mq.size(), n_fetch, n_dec + n_disc);
        end
        checks++;
        if (s_proto_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_proto_err: %b required 0", s_proto_err);
        end
    endtask

    task automatic test_credit();
        init_knobs();
        ret_en = 0; auto_retire = 0;
        begin_prog(8'h80, 1000);
        repeat (8) run_cycle();
        checks++;
        if (n_fetch != MAX_INFLIGHT || s_fetch_vld !== 1'b0) begin
            errors++;
            $display("FAIL credit_limit: fetches %0d vld %b required %0d 0", n_fetch, s_fetch_vld, MAX_INFLIGHT);
        end
        man_retire = 1;
        run_cycle();
        run_cycle();
        man_retire = 0;
        checks++;
        if (s_fetch_vld !== 1'b1) begin
            errors++;
            $display("FAIL credit_release: fetch_vld %b required 1", s_fetch_vld);
        end
        run_cycle();
        checks++;
        if (s_fetch_vld !== 1'b1) begin
            errors++;
            $display("FAIL simul_hold: fetch_vld %b required 1", s_fetch_vld);
        end
        run_cycle();
        checks++;
        if (s_fetch_vld !== 1'b0 || n_fetch != 6) begin
            errors++;
            $display("FAIL simul_full: vld %b fetches %0d required 0 6", s_fetch_vld, n_fetch);
        end
        do_reset();
    endtask

    task automatic test_backpressure();
        init_knobs();
        fst_lo = 4; fst_hi = 8; dst_lo = 2; dst_hi = 4; chk_stall_rdy = 1;
        begin_prog(8'h40, 9);
        wait_finish(300, "bp");
        checks++;
        if (n_dec != 10 || mq.size() != 0 || s_proto_err !== 1'b0) begin
            errors++;
            $display("FAIL bp_stream: dec %0d left %0d err %b required 10 0 0", n_dec, mq.size(), s_proto_err);
        end
    endtask

    task automatic test_errors();
        init_knobs();
        corrupt_idx = 3; corrupt_id = 5;
        begin_prog(8'h20, 5);
        wait_finish(200, "err");
        run_cycle();
        checks++;
        if (s_proto_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: proto_err %b required 1", s_proto_err);
        end
        init_knobs();
        fetch_rdy_en = 0; ret_en = 0; auto_retire = 0;
        begin_prog(8'h30, 1000);
        man_retire = 1;
        run_cycle();
        man_retire = 0;
        checks++;
        if (s_proto_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_on_start: proto_err %b required 0", s_proto_err);
        end
        run_cycle();
        checks++;
        if (s_proto_err !== 1'b1) begin
            errors++;
            $display("FAIL underflow_err: proto_err %b required 1", s_proto_err);
        end
        fetch_rdy_en = 1;
        repeat (8) run_cycle();
        checks++;
        if (n_fetch != MAX_INFLIGHT) begin
            errors++;
            $display("FAIL underflow_hold: fetches %0d required %0d", n_fetch, MAX_INFLIGHT);
        end
        do_reset();
    endtask

    task automatic test_reset_drain();
        init_knobs();
        auto_retire = 0;
        begin_prog(8'h50, 1);
        repeat (12) run_cycle();
        dec_hold = 1;
        run_cycle();
        dec_hold = 0;
        checks++;
        if (s_busy !== 1'b1 || s_fetch_vld !== 1'b0 || s_inst_rdy !== 1'b1) begin
            errors++;
            $display("FAIL drain_state: busy %b vld %b inst_rdy %b required 1 0 1", s_busy, s_fetch_vld, s_inst_rdy);
        end
        man_rst = 1;
        run_cycle();
        man_rst = 0;
        mq.delete(); rq.delete(); prev_stall = 0;
        run_cycle();
        checks++;
        if ({s_fetch_vld, s_inst_rdy, s_dec_vld, s_busy, s_exec_finish, s_proto_err} !== 6'b0 ||
            s_fetch_pc !== '0 || s_fetch_id !== '0) begin
            errors++;
            $display("FAIL rst_drain_outputs: vld/rdy/dec/busy/fin/err %b%b%b%b%b%b pc %h id %h required all 0",
                     s_fetch_vld, s_inst_rdy, s_dec_vld, s_busy, s_exec_finish, s_proto_err, s_fetch_pc, s_fetch_id);
        end
        repeat (4) run_cycle();
        checks++;
        if (n_finish != 0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_drain_idle: finishes %0d busy %b required 0 0", n_finish, s_busy);
        end
    endtask

    task automatic test_wrap();
        logic [PC_BIT-1:0] exp_pc;
        init_knobs();
        begin_prog(8'h00, 259);
        repeat (20) run_cycle();
        man_start = 1; man_start_pc = 8'hAA;
        run_cycle();
        man_start = 0;
        exp_pc = m_pc;
        run_cycle();
        checks++;
        if (s_fetch_pc !== exp_pc || s_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored: pc %h busy %b required %h 1", s_fetch_pc, s_busy, exp_pc);
        end
        wait_finish(3000, "wrap");
        checks++;
        if (n_dec != 260 || s_proto_err !== 1'b0 || n_fetch < 260) begin
            errors++;
            $display("FAIL wrap: dec %0d fetched %0d err %b required 260 >=260 0", n_dec, n_fetch, s_proto_err);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_pc = '0; fetch_rdy = 1'b0; inst_vld = 1'b0;
        inst_id = '0; inst_last = 1'b0; dec_rdy = 1'b0; retire_vld = 1'b0;
        prev_stall = 0;
        init_knobs();
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_credit();
        test_backpressure();
        test_errors();
        test_reset_drain();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the out-of-order CPU. It sits between the CPU's fetch request port, the instruction return bus and the decode stage. It generates sequential PCs and instruction IDs, and limits in-flight instructions with a credit counter. After the instruction flagged `inst_last` it squashes over-fetched instructions, waits for all in-flight instructions to retire, then pulses `exec_finish`.

## Interface
- `PC_BIT`, 8, width of PC
- `INST_ID_BIT`, 8, width of instruction ID; wraps modulo 2^INST_ID_BIT
- `MAX_INFLIGHT`, 4, max instructions fetched but not yet retired or discarded (≥1)

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle request to begin a program; honoured only in IDLE.
- `start_pc`  in  PC_BIT  first PC, sampled with `start`.
- `fetch_vld`  out  1  fetch request valid.
- `fetch_rdy`  in  1  fetch request accepted.
- `fetch_pc`  out  PC_BIT  PC being requested.
- `fetch_id`  out  INST_ID_BIT  ID tag for the request.
- `inst_vld`  in  1  returned instruction valid.
- `inst_rdy`  out  1  returned instruction consumed.
- `inst_id`  in  INST_ID_BIT  ID of the returned instruction.
- `inst_last`  in  1  returned instruction is the program's last.
- `dec_vld`  out  1  instruction forwarded to decode.
- `dec_rdy`  in  1  decode accepts.
- `retire_vld`  in  1  one instruction retired this cycle.
- `busy`  out  1  state ≠ IDLE.
- `exec_finish`  out  1  one-cycle pulse when the program is complete.
- `proto_err`  out  1  sticky protocol error flag.

## Operation
- **Registers:**
  - `state` ∈ {IDLE, FETCH, DRAIN, DONE}
  - `pc`
  - `next_id`, the ID of the next fetch
  - `exp_id`, the ID expected on the next returned instruction
  - `inflight`, width $clog2(MAX_INFLIGHT+1)
  - `proto_err`
- **Handshakes:**
  - fetch_hs = fetch_vld & fetch_rdy
  - ret_hs = inst_vld & inst_rdy
- **IDLE:**
  - fetch_vld=0, inst_rdy=0, dec_vld=0.
  - On `start`: pc←start_pc, next_id←0, exp_id←0, inflight←0, proto_err←0, go to FETCH.
- **FETCH:**
  - fetch_vld = (inflight < MAX_INFLIGHT); fetch_pc=pc, fetch_id=next_id.
  - On fetch_hs: pc←pc+1 and next_id←next_id+1, both wrapping.
  - Returned instructions pass through: dec_vld=inst_vld, inst_rdy=dec_rdy.
  - On ret_hs: exp_id←exp_id+1. If inst_id≠exp_id, proto_err←1.
  - On ret_hs with inst_last=1: go to DRAIN.
- **DRAIN:**
  - fetch_vld=0.
  - Every returned instruction is over-fetched and is discarded: inst_rdy=1, dec_vld=0.
  - Each discard counts as −1 on inflight, since a discarded instruction never retires.
  - When the registered inflight==0, go to DONE.
- **DONE:** exec_finish=1 for exactly one cycle, busy=1, then IDLE.
- **inflight update each cycle:** inflight ← inflight + fetch_hs − retire_vld − (DRAIN & ret_hs). All three may occur in the same cycle; the net value is applied.
- **Retire underflow:** retire_vld with inflight==0 and no fetch_hs that cycle leaves inflight at 0 and sets proto_err.
- **Ignored inputs:**
  - `start` outside IDLE.
  - retire_vld in IDLE, which also does not set proto_err.
- **Reset:**
  - State goes to IDLE; all registers clear to 0.
  - Reset dominates start and any handshake in the same cycle, and is valid mid-program; in-flight requests are abandoned.
  - All outputs read 0 in the cycle after reset: fetch_vld, inst_rdy, dec_vld, busy, exec_finish, proto_err, fetch_pc, fetch_id.

## Timing
- fetch_vld, inst_rdy, dec_vld and busy are combinational from registered state, `inflight` and the inputs `dec_rdy`/`inst_vld`. There are no combinational paths from fetch_rdy.
- fetch_pc/fetch_id are registers. They hold steady while fetch_vld=1 and fetch_rdy=0.
- The first fetch_vld appears the cycle after `start` is sampled.
- Back-to-back fetches occur every cycle while credit remains.
- With MAX_INFLIGHT=N and no retires, exactly N fetch handshakes occur, then fetch_vld=0.
- A credit freed by retire_vld in cycle t allows fetch_vld in cycle t+1.
- exec_finish is asserted in the cycle after the first cycle in which DRAIN observes registered inflight==0. It lasts one cycle; busy drops the cycle after that.
- The inst_last handshake takes effect next cycle: a fetch_hs in the same cycle as the inst_last handshake is still counted and later discarded.

## Test plan
- **Basic program:** start with start_pc=0x10. Fetch always ready; return each instruction 1 cycle after fetch; retire 3 cycles after decode. Last instruction is at PC 0x15. Required:
  - fetch_pc sequence 0x10,0x11,…
  - IDs 0,1,2,…
  - exactly 6 dec_vld handshakes
  - over-fetched PCs discarded with dec_vld=0
  - single exec_finish pulse, proto_err=0
- **Credit limit:** MAX_INFLIGHT=4, no retires. Required: exactly 4 fetch_hs, then fetch_vld=0. One retire_vld in cycle t gives fetch_vld=1 in t+1.
- **Backpressure:** fetch_rdy low for 5 cycles mid-stream, dec_rdy low for 3 cycles. Required: fetch_pc/fetch_id stable while stalled; inst_rdy=0 while dec_rdy=0; no instruction lost or duplicated.
- **Simultaneous events:** fetch_hs and retire_vld in the same cycle with inflight=MAX_INFLIGHT−1. Required: inflight unchanged.
- **Errors:** return inst_id=5 when exp_id=3, giving proto_err=1 sticky until the next start. retire_vld with inflight=0 gives proto_err=1 and inflight stays 0.
- **Reset and wrap:**
  - Assert rst during DRAIN: next cycle all outputs 0, state IDLE, no exec_finish.
  - Program of 260 instructions with INST_ID_BIT=8: ID wraps 255→0 without proto_err.
  - start in FETCH is ignored.
